demux1to8_buf: RTL and testbench
================================

DEMUX1TO8_BUF -- requirements
Module: demux1to8_buf

Interface
REQ-001 Parameter: WIDTH, default 32, data word width of input and each output slot.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: in_data  input  WIDTH  word to route.
REQ-005 Port: in_sel  input  3  destination slot index, 0..7.
REQ-006 Port: in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-008 Port: out0..out7  output  WIDTH each  registered slot data.
REQ-009 Port: out_valid  output  8  bit i = slot i holds an unconsumed word.
REQ-010 Port: out_ready  input  8  bit i = consumer i takes slot i this cycle.
REQ-011 Port: occ  output  4  registered count of set out_valid bits, 0..8.
REQ-012 Port: all_full  output  1  registered; high iff occ == 8.

Function
REQ-013 Each slot i SHALL be a one-entry buffer: data register out_i plus flag out_valid[i].
REQ-014 Input accept SHALL occur when in_valid && in_ready at a rising clk edge.
REQ-015 in_ready SHALL be combinational: !out_valid[in_sel] || out_ready[in_sel]; independent of in_valid.
REQ-016 On accept, out_<in_sel> SHALL load in_data and out_valid[in_sel] SHALL be 1 after that edge (latency 1 cycle).
REQ-017 Slot drain SHALL occur when out_valid[i] && out_ready[i]; with no accept to slot i that edge, out_valid[i] SHALL clear, out_i SHALL keep its value.
REQ-018 Drain and accept on the same slot, same edge: out_valid[i] SHALL stay 1, out_i SHALL take the new word.
REQ-019 Accept on slot j and drains on any other slots, same edge: all SHALL take effect independently; multiple simultaneous drains allowed.
REQ-020 out_ready[i] while out_valid[i]==0 SHALL have no effect.
REQ-021 While out_valid[i]==1 and out_ready[i]==0 with no accept to slot i, out_i SHALL be held stable.
REQ-022 Slots not addressed by an accept or drain SHALL hold data and flag unchanged.
REQ-023 in_valid with in_ready==0 SHALL change no state; source must hold in_data/in_sel until accepted.
REQ-024 occ SHALL equal popcount of the next-state out_valid vector, registered with it (occ always matches out_valid in the same cycle).
REQ-025 all_full SHALL be registered from the same next-state count; all_full==1 does not force in_ready low (same-cycle drain still permits accept).

Reset
REQ-026 rst_n low SHALL immediately, without clk, clear out_valid to 8'h00, out0..out7 to 0, occ to 0, all_full to 0.
REQ-027 During reset in_ready SHALL evaluate to 1 (all slots empty); accepts SHALL NOT be registered while rst_n is low.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; first accept after release behaves as from empty.
REQ-029 Reset deassertion SHALL be sampled so that the first edge with rst_n high performs normal accept/drain.

Verification
REQ-030 Basic route: reset, in_sel=5, in_data=32'hDEADBEEF, in_valid=1 one cycle -> next cycle out5=32'hDEADBEEF, out_valid=8'h20, occ=1; out_ready[5]=1 one cycle -> out_valid=8'h00, occ=0, out5 still 32'hDEADBEEF.
REQ-031 Backpressure: slot 2 full, out_ready[2]=0, offer in_sel=2 data 32'h1111 -> in_ready=0, out2 unchanged for 10 cycles; raise out_ready[2] -> in_ready=1 same cycle, next cycle out2=32'h1111, out_valid[2]=1.
REQ-032 Fill all: write 32'h0..32'h7 to slots 0..7 on 8 consecutive cycles, out_ready=0 -> occ=8, all_full=1, out_valid=8'hFF, outi=i; then out_ready=8'hFF one cycle -> occ=0, all_full=0.
REQ-033 Simultaneous: slot 3 holds 32'hA, same edge drain slot 3, drain slot 6, accept 32'hB to slot 3 -> out3=32'hB, out_valid[3]=1, out_valid[6]=0, occ decremented by 1.
REQ-034 Async reset: with occ=4, pulse rst_n low between clk edges -> outputs zero before next edge; after release, write slot 0 -> occ=1.
REQ-035 Random: constrained-random in_valid/in_sel/out_ready for 10k cycles against a per-slot scoreboard -> no lost, duplicated, or reordered words per slot; occ always equals popcount(out_valid).

Source files
------------

// File: rtl/demux1to8_buf.sv
// 1-to-8 routing demultiplexer with a one-entry valid/ready buffer per output slot.
// Occupancy count and full flag are registered alongside the slot flags so they always agree.
module demux1to8_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [3:0]       occ,
  output logic             all_full
);

  logic [WIDTH-1:0] slot_data [8];
  logic [7:0]       load;
  logic [7:0]       valid_nxt;
  logic [3:0]       occ_nxt;
  logic             accept;

  // A slot can take a new word if it is empty or is being drained on this same edge.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[in_sel] = 1'b1;
    end
    // out_ready on an empty slot clears nothing, so masking with ~out_ready is safe.
    valid_nxt = load | (out_valid & ~out_ready);
    occ_nxt   = '0;
    for (int i = 0; i < 8; i++) begin
      occ_nxt = occ_nxt + {3'b000, valid_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      occ       <= '0;
      all_full  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      out_valid <= valid_nxt;
      occ       <= occ_nxt;
      all_full  <= (occ_nxt == 4'd8);
      for (int i = 0; i < 8; i++) begin
        if (load[i]) begin
          slot_data[i] <= in_data;
        end
      end
    end
  end

  assign out0 = slot_data[0];
  assign out1 = slot_data[1];
  assign out2 = slot_data[2];
  assign out3 = slot_data[3];
  assign out4 = slot_data[4];
  assign out5 = slot_data[5];
  assign out6 = slot_data[6];
  assign out7 = slot_data[7];

endmodule

// File: tb/tb_demux1to8_buf.sv
// Scoreboard bench for demux1to8_buf: per-slot expected-word queues filled at issue time,
// drained by a monitor whenever the DUT hands a word to a consumer.
module tb_demux1to8_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [3:0]  occ;
  logic        all_full;

  logic [31:0] outs [8];
  logic [31:0] sbq [8][$];
  logic [7:0]  mvalid;
  int          checks = 0;
  int          failures = 0;

  demux1to8_buf #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .out_valid(out_valid), .out_ready(out_ready), .occ(occ), .all_full(all_full)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus just after a rising edge; the model treats each slot
  // as holding at most one word, and records issued words in that slot's queue.
  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [31:0] d,
                               input logic [7:0] r, output logic accepted);
    logic [7:0] nxt;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    accepted  = v && (!mvalid[s] || r[s]);
    nxt       = mvalid & ~r;
    if (accepted) begin
      nxt[s] = 1'b1;
      sbq[s].push_back(d);
    end
    @(posedge clk);
    mvalid = nxt;
    #1;
  endtask

  task automatic clearModel();
    mvalid = '0;
    for (int i = 0; i < 8; i++) sbq[i].delete();
  endtask

  // Monitor: checks handshake/occupancy each cycle and pops a word per consumed slot.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !mvalid[in_sel] || out_ready[in_sel]});
      checkOutput("out_valid", {24'b0, out_valid}, {24'b0, mvalid});
      checkOutput("occ_model", {28'b0, occ}, $countones(mvalid));
      checkOutput("occ_popcount", {28'b0, occ}, $countones(out_valid));
      checkOutput("all_full", {31'b0, all_full}, {31'b0, mvalid == 8'hFF});
      for (int i = 0; i < 8; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sbq[i].size() == 0) begin
            checkOutput($sformatf("dup_word_slot%0d", i), outs[i], 32'hxxxx_xxxx);
          end else begin
            checkOutput($sformatf("drain_slot%0d", i), outs[i], sbq[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    logic        pv;
    logic [2:0]  ps;
    logic [31:0] pd;
    logic [7:0]  r;
    logic        pending;

    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    clearModel();
    #3;
    checkOutput("reset_out_valid", {24'b0, out_valid}, 32'h0);
    checkOutput("reset_occ", {28'b0, occ}, 32'h0);
    checkOutput("reset_all_full", {31'b0, all_full}, 32'h0);
    checkOutput("reset_out0", out0, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic route to slot 5 and drain.
    applyStimulus(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, acc);
    checkOutput("basic_out5", out5, 32'hDEADBEEF);
    checkOutput("basic_valid", {24'b0, out_valid}, 32'h20);
    checkOutput("basic_occ", {28'b0, occ}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 8'h20, acc);
    checkOutput("drain_valid", {24'b0, out_valid}, 32'h00);
    checkOutput("drain_occ", {28'b0, occ}, 32'd0);
    checkOutput("drain_out5_kept", out5, 32'hDEADBEEF);

    // Backpressure on slot 2.
    applyStimulus(1'b1, 3'd2, 32'h2222, 8'h00, acc);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 3'd2, 32'h1111, 8'h00, acc);
      checkOutput("bp_out2_held", out2, 32'h2222);
    end
    applyStimulus(1'b1, 3'd2, 32'h1111, 8'h04, acc);
    checkOutput("bp_out2_new", out2, 32'h1111);
    checkOutput("bp_valid2", {31'b0, out_valid[2]}, 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 8'h04, acc);

    // Fill all slots, accept into a full buffer via same-edge drain, then drain all.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 32'(i), 8'h00, acc);
    checkOutput("fill_occ", {28'b0, occ}, 32'd8);
    checkOutput("fill_all_full", {31'b0, all_full}, 32'h1);
    checkOutput("fill_valid", {24'b0, out_valid}, 32'hFF);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("fill_out%0d", i), outs[i], 32'(i));
    applyStimulus(1'b1, 3'd4, 32'h44, 8'h10, acc);
    checkOutput("full_accept_out4", out4, 32'h44);
    checkOutput("full_accept_occ", {28'b0, occ}, 32'd8);
    applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, acc);
    checkOutput("empty_occ", {28'b0, occ}, 32'd0);
    checkOutput("empty_all_full", {31'b0, all_full}, 32'h0);

    // Simultaneous accept+drain on slot 3 with a drain on slot 6.
    applyStimulus(1'b1, 3'd3, 32'hA, 8'h00, acc);
    applyStimulus(1'b1, 3'd6, 32'hC, 8'h00, acc);
    applyStimulus(1'b1, 3'd3, 32'hB, 8'h48, acc);
    checkOutput("sim_out3", out3, 32'hB);
    checkOutput("sim_valid3", {31'b0, out_valid[3]}, 32'h1);
    checkOutput("sim_valid6", {31'b0, out_valid[6]}, 32'h0);
    checkOutput("sim_occ", {28'b0, occ}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, acc);

    // Asynchronous reset between edges with four words buffered.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'(i), 32'h100 + 32'(i), 8'h00, acc);
    checkOutput("pre_reset_occ", {28'b0, occ}, 32'd4);
    in_valid = 1'b0; out_ready = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {24'b0, out_valid}, 32'h0);
    checkOutput("async_occ", {28'b0, occ}, 32'h0);
    checkOutput("async_out1", out1, 32'h0);
    checkOutput("async_in_ready", {31'b0, in_ready}, 32'h1);
    #1 rst_n = 1'b1;
    clearModel();
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd0, 32'h5, 8'h00, acc);
    checkOutput("post_reset_occ", {28'b0, occ}, 32'd1);

    // Random traffic; the source holds its offer until accepted.
    pending = 1'b0; pv = 1'b0; ps = '0; pd = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 3'($urandom_range(0, 7));
        pd = $urandom;
      end
      r = ($urandom_range(0, 1) != 0) ? 8'($urandom & $urandom) : 8'($urandom);
      applyStimulus(pv, ps, pd, r, acc);
      pending = pv && !acc;
    end
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("residue_slot%0d", i), sbq[i].size(), {31'b0, mvalid[i]});
    applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF, acc);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("final_queue%0d", i), sbq[i].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
